// File: rtl/ws2812_tx_if.sv
// Pixel handshake between the blend stage (producer) and the WS2812 transmitter.
// The producer holds valid with a stable color until it sees a one-cycle ack.
interface ws2812_tx_if;
  logic [23:0] color;
  logic        valid;
  logic        ack;

  modport master (output color, output valid, input ack);
  modport slave  (input color, input valid, output ack);
endinterface

// File: rtl/ws2812_tx.sv
// WS2812 NRZ transmitter: captures {R,G,B} pixels, sends them G,R,B MSB-first,
// then holds the line low for the latch period and pulses frameDone.
module ws2812_tx #(
  parameter int BIT_CYCLES   = 20,
  parameter int T0H          = 6,
  parameter int T1H          = 13,
  parameter int RESET_CYCLES = 800,
  parameter int NUM_LEDS     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  ws2812_tx_if.slave  px,
  output logic        dout,
  output logic        busy,
  output logic        frameDone
);

  localparam int CMAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] RST_SAT  = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] T0H_C    = CW'(T0H);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H);
  localparam logic [PW-1:0] PIX_LAST = PW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic          dout_q, dout_d;
  logic          ack_q, ack_d;
  logic          fd_q, fd_d;

  logic [23:0]   grb;
  logic [CW-1:0] thigh;

  assign grb = {px.color[15:8], px.color[23:16], px.color[7:0]};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    pix_cnt_d = pix_cnt_q;
    ack_d     = 1'b0;
    fd_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cyc_cnt_q != RST_SAT) cyc_cnt_d = cyc_cnt_q + 1'b1;
        if (px.valid) begin
          shift_d   = grb;
          ack_d     = 1'b1;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
          state_d   = SEND;
        end else if (pix_cnt_q != '0 && cyc_cnt_q == RST_LAST) begin
          // Producer underrun: the LEDs have already latched on their own.
          pix_cnt_d = '0;
          fd_d      = 1'b1;
        end
      end

      SEND: begin
        if (cyc_cnt_q == BIT_LAST) begin
          cyc_cnt_d = '0;
          shift_d   = {shift_q[22:0], 1'b0};
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            if (pix_cnt_q == PIX_LAST) begin
              pix_cnt_d = '0;
              state_d   = LATCH;
            end else begin
              pix_cnt_d = pix_cnt_q + 1'b1;
              // The only edge in SEND where valid is looked at, so the
              // producer's one-cycle valid tail after ack is ignored.
              if (px.valid) begin
                shift_d = grb;
                ack_d   = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      LATCH: begin
        if (cyc_cnt_q == RST_LAST) begin
          cyc_cnt_d = '0;
          fd_d      = 1'b1;
          state_d   = IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from next-state values so dout rises on the capture edge.
  assign thigh  = shift_d[23] ? T1H_C : T0H_C;
  assign dout_d = (state_d == SEND) && (cyc_cnt_d < thigh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      pix_cnt_q <= '0;
      dout_q    <= 1'b0;
      ack_q     <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      dout_q    <= dout_d;
      ack_q     <= ack_d;
      fd_q      <= fd_d;
    end
  end

  assign px.ack    = ack_q;
  assign dout      = dout_q;
  assign frameDone = fd_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx (NUM_LEDS=3): a dout decoder feeds a pixel
// scoreboard; frame, underrun, latch-hold and reset behaviour are checked.
module tb_ws2812_tx;
  localparam int BITC = 20;
  localparam int T0   = 6;
  localparam int T1   = 13;
  localparam int RSTC = 800;
  localparam int NLED = 3;
  localparam int SAT  = 100000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dout, busy, frameDone;

  ws2812_tx_if bus();

  ws2812_tx #(
    .BIT_CYCLES(BITC), .T0H(T0), .T1H(T1), .RESET_CYCLES(RSTC), .NUM_LEDS(NLED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .px(bus), .dout(dout), .busy(busy), .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];

  // Line decoder state, sampled on the falling edge.
  int          since = SAT;
  int          high = 0;
  int          nbits = 0;
  int          nbits_after;
  logic [23:0] word = '0;
  logic        dout_prev = 1'b0;
  int          terr = 0, contig = 0, ack_cnt = 0, fd_cnt = 0, pix_total = 0;
  int          fd_since = 0, fd_pix = 0;
  longint      cyc = 0, ack_cyc = 0, fd_cyc = 0;
  logic        mon_rise, mon_end, bitval;

  assign mon_rise = dout && !dout_prev;
  assign mon_end  = (since == BITC);
  assign bitval   = (high == T1);
  always_comb nbits_after = mon_end ? ((nbits == 23) ? 0 : nbits + 1) : nbits;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.ack) begin
      ack_cnt <= ack_cnt + 1;
      ack_cyc <= cyc;
    end
    if (frameDone) begin
      fd_cnt   <= fd_cnt + 1;
      fd_cyc   <= cyc;
      fd_since <= since;
      fd_pix   <= pix_total;
    end
    if (!rst_n) begin
      dout_prev <= 1'b0;
      since     <= SAT;
      nbits     <= 0;
      high      <= 0;
    end else begin
      dout_prev <= dout;
      terr <= terr
            + ((mon_end && high != T0 && high != T1) ? 1 : 0)
            + ((mon_rise && (since < BITC || (nbits_after != 0 && !mon_end))) ? 1 : 0);
      if (mon_end) begin
        word <= {word[22:0], bitval};
        if (nbits == 23) begin
          got_q.push_back({word[22:0], bitval});
          pix_total <= pix_total + 1;
          nbits <= 0;
        end else begin
          nbits <= nbits + 1;
        end
      end
      if (mon_rise) begin
        if (nbits_after == 0 && mon_end) contig <= contig + 1;
        since <= 1;
        high  <= 1;
      end else begin
        if (since < SAT) since <= since + 1;
        if (dout) high <= high + 1;
      end
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] wire_order(input logic [23:0] c);
    return {c[15:8], c[23:16], c[7:0]};
  endfunction

  task automatic push_pixel(input logic [23:0] c, input int bound);
    int n = 0;
    exp_q.push_back(wire_order(c));
    bus.color = c;
    bus.valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack && n < bound);
    check("ack_seen", longint'(bus.ack), 1);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.color = 24'($urandom());
    $display("push color=%h after %0d cycles", c, n);
  endtask

  task automatic check_pixels(input int count);
    for (int i = 0; i < count; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        check("pixel_avail", longint'(got_q.size()), 1);
      end else begin
        logic [23:0] g, e;
        g = got_q.pop_front();
        e = exp_q.pop_front();
        $display("pixel got=%h exp=%h", g, e);
        check("pixel", g, e);
      end
    end
  endtask

  task automatic wait_fd(input int target, input int bound);
    int n = 0;
    while (fd_cnt < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("fd_wait", longint'(fd_cnt >= target), 1);
  endtask

  initial begin
    bus.color = 24'hA5A5A5;
    bus.valid = 1'b1;

    // Reset held with valid asserted.
    repeat (5) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frameDone, 0);
    bus.valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Three back-to-back pixels, then a fourth offered during the latch.
    push_pixel(24'h123456, 200);
    push_pixel(24'hABCDEF, 1000);
    push_pixel(24'h00FF01, 1000);
    push_pixel(24'h80C3F0, 3000);
    check("b2b_acks", ack_cnt, 4);
    check("b2b_fd_cnt", fd_cnt, 1);
    check("latch_ack_after_fd", ack_cyc, fd_cyc + 1);
    check("latch_len", fd_since, BITC + RSTC);
    check("frame_pixels_at_fd", fd_pix, 3);
    check("b2b_contig", contig, 2);
    check("busy_sending", busy, 1);
    check_pixels(3);

    // Fourth pixel is left alone: underrun latch closes the frame.
    wait_fd(2, 3000);
    check("underrun_len", fd_since, BITC + RSTC);
    check("underrun_pixels", fd_pix, 4);
    check("tail_no_dup_ack", ack_cnt, 4);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check_pixels(1);

    // After underrun a full frame of three pixels must end in LATCH.
    push_pixel(24'h0F0F0F, 200);
    begin
      int n = 0;
      while (pix_total < 5 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("p5_done", longint'(pix_total >= 5), 1);
    end
    repeat (50) @(negedge clk);
    @(posedge clk);
    #1;
    push_pixel(24'h5A5A5A, 200);
    push_pixel(24'hFFFFFF, 1000);
    wait_fd(3, 3000);
    check("frame2_len", fd_since, BITC + RSTC);
    check("frame2_pixels_at_fd", fd_pix, 7);
    check("frame2_contig", contig, 3);
    check("frame2_terr", terr, 0);
    check_pixels(3);

    // Reset in the high phase of a bit drops the line at once.
    repeat (5) @(posedge clk);
    #1;
    push_pixel(24'h00FF00, 200);
    check("pre_rst_dout", dout, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", dout, 0);
    check("async_rst_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (900) @(negedge clk);
    check("rst_no_ack", ack_cnt, 8);
    check("rst_no_fd", fd_cnt, 3);
    check("rst_no_pixel", got_q.size(), 0);
    check("rst_idle_dout", dout, 0);
    check("total_terr", terr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

Serial transmitter for WS2812-class addressable LEDs. It is the downstream end of the blend stage's `validOut`/`ack` output handshake. It accepts one 24-bit {R,G,B} pixel per handshake, reorders it to the wire order G,R,B, and drives it MSB-first on a single NRZ data line. After `NUM_LEDS` pixels it holds the line low for the latch/reset period and pulses `frameDone`.

## Interface
- `BIT_CYCLES`, 20: clock cycles per bit (1.25 µs at 16 MHz).
- `T0H`, 6: high cycles for a 0 bit.
- `T1H`, 13: high cycles for a 1 bit.
- `RESET_CYCLES`, 800: low cycles for the latch period (50 µs at 16 MHz).
- `NUM_LEDS`, 64: pixels per frame.
- Legal parameter set: 0 < `T0H` < `T1H` < `BIT_CYCLES`; `NUM_LEDS` ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `color`  in  24  pixel {R[23:16], G[15:8], B[7:0]}; valid while `valid`=1.
- `valid`  in  1  producer holds high until it sees `ack`, then drops it on the following edge.
- `ack`  out  1  registered; exactly one-cycle pulse per captured pixel.
- `dout`  out  1  registered LED data line.
- `busy`  out  1  1 when state ≠ IDLE.
- `frameDone`  out  1  one-cycle pulse at the end of each latch period.

## Operation
- Reset values: `dout`=0, `ack`=0, `busy`=0, `frameDone`=0, state=IDLE, all counters 0.
- Reset asserted mid-bit or mid-latch forces `dout` low immediately and abandons the frame. No `ack` or `frameDone` follows.
- Internal registers:
  - `shift[23:0]`
  - `bitCnt` (0..23)
  - `cycCnt`, wide enough for max(`BIT_CYCLES`, `RESET_CYCLES`)
  - `pixCnt` (0..`NUM_LEDS`-1)
- State machine:
  - **IDLE:** `dout`=0, `cycCnt` counts idle cycles (saturating).
    - If `valid`=1: capture `shift`={G,R,B}, pulse `ack`, clear `bitCnt`/`cycCnt`, go to SEND.
    - If `pixCnt`≠0 and the idle count reaches `RESET_CYCLES` (underrun; the LEDs have latched by themselves): set `pixCnt`←0 and pulse `frameDone`.
  - **SEND:** `dout`=1 while `cycCnt` < (`shift[23]` ? `T1H` : `T0H`), else 0.
    - At `cycCnt`=`BIT_CYCLES`-1: shift left by 1, increment `bitCnt`, clear `cycCnt`.
    - End of bit 23, pixel complete:
      - If `pixCnt`=`NUM_LEDS`-1: set `pixCnt`←0 and go to LATCH.
      - Else increment `pixCnt`. If `valid`=1, capture the next pixel and `ack` on this same edge (no gap between pixels); otherwise go to IDLE.
  - **LATCH:** `dout`=0 for `RESET_CYCLES` cycles, then pulse `frameDone` and go to IDLE. `valid` is ignored; no `ack` is issued.
- `valid` is not sampled in SEND except on the final edge of bit 23. This makes the producer's one-cycle `valid` tail after `ack` harmless.
- `color` is sampled only on the capture edge; later changes do not affect the pixel in flight.

## Timing
- Capture edge E: `ack`=1 during cycle E..E+1, and `dout` rises on edge E.
- Bit k of a pixel occupies cycles E+k·`BIT_CYCLES` .. E+(k+1)·`BIT_CYCLES`-1. The high phase lasts exactly `T0H` or `T1H` cycles at the start of each bit.
- Pixel duration: 24·`BIT_CYCLES` = 480 cycles (default).
- With `valid` already high at the end of bit 23, the next pixel's first rising edge lands exactly `BIT_CYCLES` after the previous bit's start. There are no extra cycles.
- From IDLE, the latency from `valid` rising (sampled at edge E) to the first `dout` edge is 0 cycles, i.e. edge E.
- The latch period begins on the edge after the last bit's final cycle. `frameDone` is high for the single cycle following the `RESET_CYCLES`-th low cycle.
- `busy` falls on the same edge the state enters IDLE.

## Test plan
- **Reset:** hold `rst_n`=0 with `valid`=1 → `dout`=0, `ack`=0, `busy`=0, `frameDone`=0. Assert `rst_n`=0 mid-bit → `dout`=0 immediately (asynchronous) and no `ack`.
- **Single pixel, `NUM_LEDS`=1:** `color`=24'hFF0000 → wire bits 00000000_11111111_00000000. Check high phases 6/13 cycles and each bit exactly 20 cycles. Then 800 low cycles, then a one-cycle `frameDone`.
- **Back-to-back, `NUM_LEDS`=3:** pixels 24'h123456, 24'hABCDEF, 24'h00FF01 with `valid` reasserted immediately after each `ack` → 72 contiguous bits with no gap. Decoded stream is GRB-ordered 34_12_56, CD_AB_EF, FF_00_01. Exactly 3 `ack` pulses.
- **Handshake tail:** producer keeps `valid`=1 for one cycle after `ack` → no second `ack` and no duplicate pixel.
- **Underrun, `NUM_LEDS`=4:** send 2 pixels, then idle 800 cycles → `frameDone` pulses and `pixCnt` resets. The next 4 pixels form a full frame ending in LATCH.
- **Valid during LATCH:** `valid`=1 throughout the latch period → no `ack` until the cycle after `frameDone`; the pixel is then captured from IDLE.
